// File: rtl/edge_pulse_tx.sv
// edge_pulse_tx: turns single-cycle trigger requests into well-spaced level
// pulses on sig. Each pulse is high for HIGH_CYC cycles and is followed by at
// least LOW_CYC low cycles, so a 4-flop synchronizing edge detector captures
// every pulse exactly once. Triggers that arrive while a pulse is in flight
// are counted in pend_cnt. A trigger is dropped only when that counter is
// already saturated; a dropped trigger sets the sticky ovf flag.
// Optional macro EDGE_PULSE_TX_INV_EN inverts sig. sig then idles and resets
// at 1, and each pulse drives 0 instead of 1.
module edge_pulse_tx #(
  parameter int unsigned HIGH_CYC = 4,
  parameter int unsigned LOW_CYC  = 4,
  parameter int unsigned PEND_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              ovf_clr,
  output logic              sig,
  output logic              busy,
  output logic              done,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

`ifdef EDGE_PULSE_TX_INV_EN
  localparam logic SIG_IDLE = 1'b1;
`else
  localparam logic SIG_IDLE = 1'b0;
`endif
  localparam logic SIG_ACT = ~SIG_IDLE;

  localparam logic [7:0]        HIGH_LAST = 8'(HIGH_CYC - 1);
  localparam logic [7:0]        LOW_LAST  = 8'(LOW_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = '0;

  // Parameters outside the legal range would wrap the 8-bit phase counter
  if (HIGH_CYC < 2 || HIGH_CYC > 255) begin : g_bad_high
    $error("edge_pulse_tx: HIGH_CYC must be within 2..255");
  end
  if (LOW_CYC < 2 || LOW_CYC > 255) begin : g_bad_low
    $error("edge_pulse_tx: LOW_CYC must be within 2..255");
  end
  if (PEND_W < 1) begin : g_bad_pend
    $error("edge_pulse_tx: PEND_W must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                sig_q, sig_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                low_exit_s;
  logic                drop_s;

  // Next state and phase counter: the counter restarts at 0 on every phase entry
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    low_exit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (trig) begin
          state_d = ST_HIGH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          state_d = ST_LOW;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_LOW: begin
        if (cnt_q == LOW_LAST) begin
          low_exit_s = 1'b1;
          cnt_d      = 8'd0;
          // A trigger arriving on the exit cycle behaves as queued-then-consumed
          if (trig || (pend_q != PEND_ZERO)) begin
            state_d = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Pending counter and sticky overflow; a simultaneous set beats ovf_clr
  always_comb begin
    pend_d = pend_q;
    drop_s = 1'b0;
    if (low_exit_s) begin
      if (trig) begin
        // Increment and decrement cancel, or a fresh trigger is consumed at once
        pend_d = pend_q;
      end else if (pend_q != PEND_ZERO) begin
        pend_d = pend_q - PEND_ONE;
      end else begin
        pend_d = pend_q;
      end
    end else if (trig && (state_q != ST_IDLE)) begin
      if (pend_q == PEND_MAX) begin
        drop_s = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else begin
      pend_d = pend_q;
    end

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Registered outputs are derived from the next state so they line up with it
  always_comb begin
    sig_d  = (state_d == ST_HIGH) ? SIG_ACT : SIG_IDLE;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_LOW) && (cnt_d == LOW_LAST);
  end

  // State and output registers; reset drops sig at once and discards the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      pend_q  <= PEND_ZERO;
      ovf_q   <= 1'b0;
      sig_q   <= SIG_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sig      = sig_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pend_cnt = pend_q;
  assign ovf      = ovf_q;

endmodule
